// File: rtl/debug_view_pkg.sv
// Shared types and constants for the debug register viewer: FSM state encoding,
// display reset patterns and the active-low seven-segment lookup.
package debug_view_pkg;

    typedef enum logic [1:0] {
        ST_SELECT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SHOW
    } state_t;

    localparam logic [7:0] AN_RESET       = 8'hFE;
    localparam logic [6:0] SEG_BLANK_ZERO = 7'b0000001;

    // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
    function automatic logic [6:0] seg7(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern; purely combinational.
module seg7_decode
    import debug_view_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = seg7(i_nibble);

endmodule

// File: rtl/debug_view_ctrl.sv
// Steps the core's debug read port through register indices, captures each value into a
// shadow register and multiplexes it onto an 8-digit seven-segment display and LEDs.
module debug_view_ctrl
    import debug_view_pkg::*;
#(
    parameter int SCAN_DIV = 500,
    parameter int SETTLE   = 2,
    parameter int DWELL    = 25000000,
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        step,
    input  logic        auto_en,
    input  logic        freeze,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_sel,
    output logic [6:0]  sev_out,
    output logic [7:0]  an,
    output logic [15:0] led
);

    localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DWELL_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
    localparam logic [4:0]          IDX_LAST    = 5'(NUM_REGS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [4:0]           r_idx;
    logic [4:0]           r_reg_sel;
    logic [31:0]          r_shadow;
    logic [SETTLE_W-1:0]  r_settle_cnt;
    logic [DWELL_W-1:0]   r_dwell_cnt;
    logic [SCAN_W-1:0]    r_scan_cnt;
    logic [2:0]           r_digit;
    logic [2:0]           w_digit_next;
    logic [7:0]           r_an;
    logic [3:0]           w_nibble;

    logic w_load_sel;
    logic w_settle_inc;
    logic w_capture;
    logic w_live;
    logic w_dwell_inc;
    logic w_advance;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state <= ST_SELECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load_sel   = 1'b0;
        w_settle_inc = 1'b0;
        w_capture    = 1'b0;
        w_live       = 1'b0;
        w_dwell_inc  = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_SELECT: begin
                w_load_sel   = 1'b1;
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_settle_inc = 1'b1;
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_capture    = 1'b1;
                w_state_next = ST_SHOW;
            end
            ST_SHOW: begin
                w_live      = ~freeze;
                w_dwell_inc = auto_en;
                // A step landing on dwell expiry still yields a single advance.
                if (step || (auto_en && (r_dwell_cnt == DWELL_LAST))) begin
                    w_advance    = 1'b1;
                    w_state_next = ST_SELECT;
                end
            end
            default: w_state_next = ST_SELECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_idx        <= '0;
            r_reg_sel    <= '0;
            r_shadow     <= '0;
            r_settle_cnt <= '0;
            r_dwell_cnt  <= '0;
        end else begin
            if (w_load_sel) begin
                r_reg_sel    <= r_idx;
                r_settle_cnt <= '0;
            end else if (w_settle_inc) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end

            if (w_capture || w_live) begin
                r_shadow <= reg_data;
            end

            // Held while auto_en is low so the dwell resumes where it paused.
            if (w_capture) begin
                r_dwell_cnt <= '0;
            end else if (w_dwell_inc && !w_advance) begin
                r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end

            if (w_advance) begin
                r_idx <= (r_idx == IDX_LAST) ? 5'd0 : r_idx + 5'd1;
            end
        end
    end

    assign w_digit_next = r_digit + 3'd1;

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
            r_an       <= AN_RESET;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_digit    <= w_digit_next;
            r_an       <= ~(8'b1 << w_digit_next);
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // No frame buffer: a shadow update shows on the lit digit immediately.
    assign w_nibble = r_shadow[{r_digit, 2'b00} +: 4];

    seg7_decode u_seg7_decode (
        .i_nibble (w_nibble),
        .o_seg    (sev_out)
    );

    assign reg_sel = r_reg_sel;
    assign an      = r_an;
    assign led     = r_shadow[15:0];

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Self-checking bench for debug_view_ctrl with a small core model on the debug port.
module tb_debug_view_ctrl;

    logic        clk;
    logic        Rst;
    logic        step;
    logic        auto_en;
    logic        freeze;
    logic [31:0] reg_data;
    logic [4:0]  reg_sel;
    logic [6:0]  sev_out;
    logic [7:0]  an;
    logic [15:0] led;

    logic        override_en;
    logic [31:0] override_val;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] an;
        logic [6:0] sev;
    } scan_vec_t;

    typedef struct {
        logic [4:0]  sel;
        logic [15:0] led;
    } sb_t;

    scan_vec_t scan_tbl [9];
    sb_t       sb_q [$];

    debug_view_ctrl #(
        .SCAN_DIV (4),
        .SETTLE   (2),
        .DWELL    (20),
        .NUM_REGS (32)
    ) dut (
        .clk      (clk),
        .Rst      (Rst),
        .step     (step),
        .auto_en  (auto_en),
        .freeze   (freeze),
        .reg_data (reg_data),
        .reg_sel  (reg_sel),
        .sev_out  (sev_out),
        .an       (an),
        .led      (led)
    );

    // Core model: debug_output follows debug_input unless a test forces a value.
    assign reg_data = override_en ? override_val : (32'h1000_0000 + {27'd0, reg_sel});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic do_step(input logic [4:0] exp_sel);
        sb_t e;
        e.sel = exp_sel;
        e.led = {11'd0, exp_sel};
        sb_q.push_back(e);
        pulse_step();
    endtask

    // Called just after the edge that sampled the step.
    task automatic check_step_result(input logic [15:0] old_led);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            tick(1);
            check("sel_after_t1", 32'(reg_sel), 32'(e.sel));
            tick(2);
            check("led_before_capture", 32'(led), 32'(old_led));
            tick(2);
            check("sel_settled", 32'(reg_sel), 32'(e.sel));
            check("led_after_t5", 32'(led), 32'(e.led));
        end
    endtask

    task automatic wait_an(input logic [7:0] target, input bit want_eq, input string name);
        int n;
        n = 0;
        while (((an == target) != want_eq) && (n < 64)) begin
            @(negedge clk);
            n++;
        end
        if ((an == target) != want_eq) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got an=%h after timeout expected %s %h", name, an,
                     want_eq ? "==" : "!=", target);
        end
    endtask

    initial begin
        scan_tbl[0] = '{an: 8'hFE, sev: 7'b0111000};
        scan_tbl[1] = '{an: 8'hFD, sev: 7'b0110000};
        scan_tbl[2] = '{an: 8'hFB, sev: 7'b1000010};
        scan_tbl[3] = '{an: 8'hF7, sev: 7'b0110001};
        scan_tbl[4] = '{an: 8'hEF, sev: 7'b1100000};
        scan_tbl[5] = '{an: 8'hDF, sev: 7'b0001000};
        scan_tbl[6] = '{an: 8'hBF, sev: 7'b0000100};
        scan_tbl[7] = '{an: 8'h7F, sev: 7'b0000000};
        scan_tbl[8] = '{an: 8'hFE, sev: 7'b0111000};

        Rst          = 1'b1;
        step         = 1'b0;
        auto_en      = 1'b0;
        freeze       = 1'b0;
        override_en  = 1'b0;
        override_val = 32'h0;

        // Reset and first capture.
        tick(3);
        check("rst_an", 32'(an), 32'hFE);
        check("rst_sev", 32'(sev_out), 32'b0000001);
        check("rst_sel", 32'(reg_sel), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        Rst = 1'b0;
        tick(3);
        check("boot_sel", 32'(reg_sel), 32'h0);
        tick(1);
        check("boot_led", 32'(led), 32'h0);
        check("boot_an_digit1", 32'(an), 32'hFD);
        tick(24);
        check("boot_an_digit7", 32'(an), 32'h7F);
        check("boot_sev_digit7", 32'(sev_out), 32'b1001111);
        tick(4);
        check("boot_an_wrap", 32'(an), 32'hFE);
        check("boot_sev_wrap", 32'(sev_out), 32'b0000001);

        // Single step, then no further advance without another step.
        do_step(5'd1);
        check_step_result(16'h0000);
        tick(10);
        check("no_auto_advance", 32'(reg_sel), 32'h1);

        for (int k = 2; k <= 31; k++) begin
            do_step(5'(k));
            check_step_result(16'(k - 1));
        end

        // Auto dwell from index 31 wraps to 0.
        auto_en = 1'b1;
        tick(20);
        check("dwell_before_wrap_sel", 32'(reg_sel), 32'd31);
        check("dwell_before_wrap_led", 32'(led), 32'h001F);
        tick(1);
        check("dwell_wrap_sel", 32'(reg_sel), 32'h0);
        tick(4);
        check("dwell_wrap_led", 32'(led), 32'h0000);

        // Step coincident with the next dwell expiry: one advance only.
        tick(18);
        check("coincide_pre_sel", 32'(reg_sel), 32'h0);
        do_step(5'd1);
        auto_en = 1'b0;
        check_step_result(16'h0000);
        tick(30);
        check("coincide_hold_sel", 32'(reg_sel), 32'h1);

        // Step during SETTLE is dropped.
        do_step(5'd2);
        tick(1);
        pulse_step();
        tick(3);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("settle_step_sel", 32'(reg_sel), 32'(e.sel));
            check("settle_step_led", 32'(led), 32'(e.led));
        end
        tick(10);
        check("settle_step_dropped", 32'(reg_sel), 32'h2);

        // Freeze holds the shadow; release picks up the new value next cycle.
        freeze       = 1'b1;
        override_val = 32'hDEAD_BEEF;
        override_en  = 1'b1;
        tick(3);
        check("freeze_hold_led", 32'(led), 32'h0002);
        freeze = 1'b0;
        tick(1);
        check("freeze_release_led", 32'(led), 32'hBEEF);

        // Digit scan over a known shadow value.
        override_val = 32'h89AB_CDEF;
        tick(1);
        wait_an(8'hFE, 1'b0, "scan_sync_leave");
        wait_an(8'hFE, 1'b1, "scan_sync_enter");
        for (int i = 0; i < 9; i++) begin
            check($sformatf("scan_an_%0d", i), 32'(an), 32'(scan_tbl[i].an));
            check($sformatf("scan_sev_%0d", i), 32'(sev_out), 32'(scan_tbl[i].sev));
            tick(4);
        end
        tick(1);
        override_val = 32'h89AB_CD3F;
        tick(1);
        check("midscan_an", 32'(an), 32'hFD);
        check("midscan_sev", 32'(sev_out), 32'b0000110);

        // Reset asserted while in SETTLE.
        override_en = 1'b0;
        tick(1);
        pulse_step();
        tick(1);
        Rst = 1'b1;
        tick(1);
        check("midrst_an", 32'(an), 32'hFE);
        check("midrst_sev", 32'(sev_out), 32'b0000001);
        check("midrst_sel", 32'(reg_sel), 32'h0);
        check("midrst_led", 32'(led), 32'h0);
        Rst = 1'b0;
        tick(5);
        check("postrst_sel", 32'(reg_sel), 32'h0);
        check("postrst_an", 32'(an), 32'hFD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
